tc_multi: RTL and testbench

- Parametrised multi-channel timer/counter peripheral on the processor's bridge (PrAddr/WE/DataIn/DataOut), successor to the single-channel TC.
- Adds per-channel clock prescaler, a free-running up-count mode, a sticky write-1-to-clear pending flag, and per-channel plus combined interrupt request lines.
- Feeds the CP0 hardware-interrupt inputs.

---
 rtl/tc_multi.sv | 162 ++++++++++++++++
 tb/tb_tc_multi.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_multi.sv
// Multi-channel timer/counter on the processor bridge. Each channel has a prescaler,
// one-shot / auto-reload / free-run counting, a sticky W1C pending flag and a masked IRQ.
module tc_multi #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2,
    parameter int WIDTH   = 32,
    parameter int PS_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CH_BITS+1:0]   PrAddr,
    input  logic                 WE,
    input  logic [31:0]          DataIn,
    output logic [31:0]          DataOut,
    output logic [NUM_CH-1:0]    IRQ,
    output logic                 InterruptRequest
);
    localparam int AW = CH_BITS + 2;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PRESET  = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;
    localparam logic [1:0] MODE_RELOAD = 2'b01;
    localparam logic [1:0] MODE_FREE   = 2'b10;

    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] im_q, im_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [1:0]        mode_q   [NUM_CH];
    logic [1:0]        mode_d   [NUM_CH];
    logic [PS_W-1:0]   pscale_q [NUM_CH];
    logic [PS_W-1:0]   pscale_d [NUM_CH];
    logic [PS_W-1:0]   ps_q     [NUM_CH];
    logic [PS_W-1:0]   ps_d     [NUM_CH];
    logic [WIDTH-1:0]  preset_q [NUM_CH];
    logic [WIDTH-1:0]  preset_d [NUM_CH];
    logic [WIDTH-1:0]  count_q  [NUM_CH];
    logic [WIDTH-1:0]  count_d  [NUM_CH];

    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] expire;
    logic [AW-1:0]     ch_sel;
    logic [1:0]        reg_sel;
    logic              unused_datain;

    assign ch_sel        = PrAddr >> 2;
    assign reg_sel       = PrAddr[1:0];
    assign unused_datain = &{1'b0, DataIn};

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            tick[i]   = en_q[i] && (ps_q[i] == pscale_q[i]);
            wr_sel[i] = WE && (ch_sel == AW'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            en_d[i]     = en_q[i];
            im_d[i]     = im_q[i];
            mode_d[i]   = mode_q[i];
            pscale_d[i] = pscale_q[i];
            preset_d[i] = preset_q[i];
            count_d[i]  = count_q[i];
            expire[i]   = 1'b0;

            if (!en_q[i] || tick[i]) ps_d[i] = '0;
            else                     ps_d[i] = ps_q[i] + PS_W'(1);

            if (tick[i]) begin
                if (mode_q[i] == MODE_FREE) begin
                    count_d[i] = count_q[i] + WIDTH'(1);
                    expire[i]  = &count_q[i];
                end else if (count_q[i] <= WIDTH'(1)) begin
                    expire[i] = 1'b1;
                    if (mode_q[i] == MODE_RELOAD) begin
                        count_d[i] = preset_q[i];
                    end else begin
                        count_d[i] = '0;
                        en_d[i]    = 1'b0;
                    end
                end else begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end
            end

            // A bus write replaces whatever the tick did to COUNT and EN this cycle
            if (wr_sel[i]) begin
                case (reg_sel)
                    REG_CTRL: begin
                        en_d[i]     = DataIn[0];
                        mode_d[i]   = DataIn[2:1];
                        im_d[i]     = DataIn[3];
                        pscale_d[i] = DataIn[PS_W+3:4];
                        ps_d[i]     = '0;
                        if (DataIn[0])
                            count_d[i] = (DataIn[2:1] == MODE_FREE) ? '0 : preset_q[i];
                        else
                            count_d[i] = count_q[i];
                    end
                    REG_PRESET: preset_d[i] = DataIn[WIDTH-1:0];
                    REG_COUNT: begin
                        count_d[i] = DataIn[WIDTH-1:0];
                        en_d[i]    = en_q[i];
                    end
                    default: ;
                endcase
            end

            // A new expiry wins over a simultaneous write-1-to-clear
            pend_d[i] = (pend_q[i] && !(wr_sel[i] && (reg_sel == REG_STATUS) && DataIn[0]))
                        || expire[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            en_q   <= '0;
            im_q   <= '0;
            pend_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]   <= '0;
                pscale_q[i] <= '0;
                ps_q[i]     <= '0;
                preset_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            en_q   <= en_d;
            im_q   <= im_d;
            pend_q <= pend_d;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]   <= mode_d[i];
                pscale_q[i] <= pscale_d[i];
                ps_q[i]     <= ps_d[i];
                preset_q[i] <= preset_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    // Unmatched channel indices fall through to zero
    always_comb begin
        DataOut = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == AW'(i)) begin
                case (reg_sel)
                    REG_CTRL:   DataOut = 32'({pscale_q[i], im_q[i], mode_q[i], en_q[i]});
                    REG_PRESET: DataOut = 32'(preset_q[i]);
                    REG_COUNT:  DataOut = 32'(count_q[i]);
                    default:    DataOut = {30'b0, en_q[i], pend_q[i]};
                endcase
            end
        end
    end

    assign IRQ              = pend_q & im_q;
    assign InterruptRequest = |IRQ;

endmodule

// File: tb/tb_tc_multi.sv
// Bench for tc_multi: directed scenarios plus random bus traffic against a
// cycle-scheduled reference model of the timer channels.
module tb_tc_multi;
    localparam int NUM_CH  = 4;
    localparam int CH_BITS = 2;
    localparam int WIDTH   = 32;
    localparam int PS_W    = 8;
    localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              WE = 1'b0;
    logic [3:0]        PrAddr = '0;
    logic [31:0]       DataIn = '0;
    logic [31:0]       DataOut;
    logic [NUM_CH-1:0] IRQ;
    logic              InterruptRequest;

    int errors = 0;
    int checks = 0;

    tc_multi #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .WIDTH(WIDTH), .PS_W(PS_W)) dut (
        .clk(clk), .reset(reset), .PrAddr(PrAddr), .WE(WE), .DataIn(DataIn),
        .DataOut(DataOut), .IRQ(IRQ), .InterruptRequest(InterruptRequest)
    );

    always #20 clk = ~clk;

    // Reference model: each enabled channel has an absolute cycle number of its next tick
    longint unsigned cyc = 0;
    bit              m_en     [NUM_CH];
    bit [1:0]        m_mode   [NUM_CH];
    bit              m_im     [NUM_CH];
    int              m_psc    [NUM_CH];
    longint unsigned m_preset [NUM_CH];
    longint unsigned m_count  [NUM_CH];
    longint unsigned m_next   [NUM_CH];
    bit              m_pend   [NUM_CH];

    always @(posedge clk) begin : ref_model
        bit tick, set, clr, wr, ne;
        longint unsigned nc;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!reset) begin
                m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_psc[c] = 0;
                m_preset[c] = 0; m_count[c] = 0; m_next[c] = 0; m_pend[c] = 0;
            end else begin
                tick = m_en[c] && (cyc == m_next[c]);
                set = 0; nc = m_count[c]; ne = m_en[c];
                if (tick) begin
                    m_next[c] = cyc + longint'(m_psc[c]) + 1;
                    if (m_mode[c] == 2'b10) begin
                        if (m_count[c] == MAXV) begin nc = 0; set = 1; end
                        else nc = m_count[c] + 1;
                    end else if (m_count[c] <= 1) begin
                        set = 1;
                        if (m_mode[c] == 2'b01) nc = m_preset[c];
                        else begin nc = 0; ne = 0; end
                    end else begin
                        nc = m_count[c] - 1;
                    end
                end
                wr  = WE && (int'(PrAddr[3:2]) == c);
                clr = wr && (PrAddr[1:0] == 2'd3) && DataIn[0];
                if (wr && PrAddr[1:0] == 2'd0) begin
                    ne = DataIn[0];
                    m_mode[c] = DataIn[2:1];
                    m_im[c] = DataIn[3];
                    m_psc[c] = int'(DataIn[PS_W+3:4]);
                    m_next[c] = cyc + 1 + longint'(DataIn[PS_W+3:4]);
                    if (DataIn[0]) nc = (DataIn[2:1] == 2'b10) ? 0 : m_preset[c];
                    else nc = m_count[c];
                end
                if (wr && PrAddr[1:0] == 2'd1) m_preset[c] = longint'(DataIn);
                if (wr && PrAddr[1:0] == 2'd2) begin nc = longint'(DataIn); ne = m_en[c]; end
                m_count[c] = nc;
                m_en[c] = ne;
                m_pend[c] = (m_pend[c] && !clr) || set;
            end
        end
        cyc++;
    end

    function automatic logic [31:0] exp_read(input int ch, input int r);
        case (r)
            0: return (32'(m_psc[ch]) << 4) | (32'(m_im[ch]) << 3) |
                      (32'(m_mode[ch]) << 1) | 32'(m_en[ch]);
            1: return m_preset[ch][31:0];
            2: return m_count[ch][31:0];
            default: return {30'b0, m_en[ch], m_pend[ch]};
        endcase
    endfunction

    function automatic logic [NUM_CH-1:0] exp_irq();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_pend[c] & m_im[c];
        return v;
    endfunction

    task automatic peek(input int ch, input int r, output logic [31:0] v);
        WE = 1'b0;
        PrAddr = 4'(ch * 4 + r);
        #1;
        v = DataOut;
    endtask

    task automatic step(input logic we, input int ch, input int r, input logic [31:0] d);
        WE = we;
        PrAddr = 4'(ch * 4 + r);
        DataIn = d;
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < 4; r++) begin
                peek(c, r, v);
                checks++;
                if (v !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_read ch%0d reg%0d: got %h expected 0", c, r, v);
                end
            end
        checks++;
        if (IRQ !== '0 || InterruptRequest !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got IRQ=%b IR=%b expected 0/0", IRQ, InterruptRequest);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        step(1'b1, 0, 1, 32'd5);
        step(1'b1, 0, 0, 32'h9);
        for (int k = 0; k < 5; k++) begin
            peek(0, 2, v);
            checks++;
            if (v !== 32'(5 - k)) begin
                errors++;
                $display("FAIL oneshot_count step%0d: got %0d expected %0d", k, v, 5 - k);
            end
            idle(1);
        end
        peek(0, 2, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL oneshot_zero: got %h expected 0", v); end
        peek(0, 3, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL oneshot_status: got %h expected 1", v); end
        peek(0, 0, v);
        checks++;
        if (v !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl: got %h expected 8", v); end
        checks++;
        if (IRQ[0] !== 1'b1) begin errors++; $display("FAIL oneshot_irq: got %b expected 1", IRQ[0]); end
        idle(2);
        peek(0, 2, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL oneshot_hold: got %h expected 0", v); end
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        int n;
        bit found;
        step(1'b1, 1, 1, 32'd3);
        step(1'b1, 1, 0, 32'h2B);
        n = 0; found = 0;
        while (n < 20 && !found) begin
            idle(1); n++;
            peek(1, 3, v);
            found = v[0];
        end
        checks++;
        if (!found || n != 9) begin
            errors++;
            $display("FAIL reload_first_expiry: got found=%0d after %0d cycles expected 9", found, n);
        end
        peek(1, 2, v);
        checks++;
        if (v !== 32'd3) begin errors++; $display("FAIL reload_count: got %0d expected 3", v); end
        step(1'b1, 1, 3, 32'h1);
        peek(1, 3, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL reload_w1c: got %h expected 2", v); end
        checks++;
        if (IRQ[1] !== 1'b0) begin errors++; $display("FAIL reload_irq_drop: got %b expected 0", IRQ[1]); end
        n = 0; found = 0;
        while (n < 20 && !found) begin
            idle(1); n++;
            peek(1, 3, v);
            found = v[0];
        end
        checks++;
        if (!found || n != 8 || IRQ[1] !== 1'b1) begin
            errors++;
            $display("FAIL reload_reexpiry: got found=%0d n=%0d irq=%b expected 1/8/1", found, n, IRQ[1]);
        end
    endtask

    task automatic test_freerun();
        logic [31:0] v;
        step(1'b1, 2, 2, 32'hFFFF_FFFE);
        step(1'b1, 2, 0, 32'h5);
        peek(2, 2, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL free_ctrl_zero: got %h expected 0", v); end
        step(1'b1, 2, 2, 32'hFFFF_FFFE);
        peek(2, 2, v);
        checks++;
        if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL free_write: got %h expected fffffffe", v); end
        idle(1);
        peek(2, 2, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL free_inc: got %h expected ffffffff", v); end
        idle(1);
        peek(2, 2, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL free_wrap: got %h expected 0", v); end
        peek(2, 3, v);
        checks++;
        if (v !== 32'h3) begin errors++; $display("FAIL free_status: got %h expected 3", v); end
        checks++;
        if (IRQ[2] !== 1'b0) begin errors++; $display("FAIL free_masked: got %b expected 0", IRQ[2]); end
        step(1'b1, 2, 0, 32'hD);
        checks++;
        if (IRQ[2] !== 1'b1 || InterruptRequest !== 1'b1) begin
            errors++;
            $display("FAIL free_unmask: got IRQ2=%b IR=%b expected 1/1", IRQ[2], InterruptRequest);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] v;
        bit hit;
        step(1'b1, 1, 3, 32'h1);
        hit = 0;
        for (int n = 0; n < 20; n++) begin
            if (m_en[1] && m_next[1] == cyc && m_count[1] <= 1) begin
                step(1'b1, 1, 3, 32'h1);
                hit = 1;
                break;
            end
            idle(1);
        end
        peek(1, 3, v);
        checks++;
        if (!hit || v[0] !== 1'b1) begin
            errors++;
            $display("FAIL sim_w1c_vs_expiry: got hit=%0d pend=%b expected 1/1", hit, v[0]);
        end
        step(1'b1, 0, 1, 32'd7);
        step(1'b1, 0, 0, 32'h9);
        idle(1);
        peek(0, 2, v);
        checks++;
        if (v !== 32'd6) begin errors++; $display("FAIL sim_pre_tick: got %0d expected 6", v); end
        step(1'b1, 0, 0, 32'h9);
        peek(0, 2, v);
        checks++;
        if (v !== 32'd7) begin errors++; $display("FAIL sim_ctrl_wins: got %0d expected 7", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        step(1'b1, 3, 1, 32'd2);
        step(1'b1, 3, 0, 32'hB);
        step(1'b1, 0, 1, 32'd1);
        step(1'b1, 0, 0, 32'hB);
        idle(4);
        peek(0, 3, v);
        checks++;
        if (v !== 32'h3) begin errors++; $display("FAIL mid_ch0_status: got %h expected 3", v); end
        peek(3, 3, v);
        checks++;
        if (v !== 32'h3) begin errors++; $display("FAIL mid_ch3_status: got %h expected 3", v); end
        reset = 1'b0;
        idle(1);
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < 4; r++) begin
                peek(c, r, v);
                checks++;
                if (v !== 32'h0) begin
                    errors++;
                    $display("FAIL mid_reset_read ch%0d reg%0d: got %h expected 0", c, r, v);
                end
            end
        checks++;
        if (IRQ !== '0 || InterruptRequest !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_irq: got IRQ=%b IR=%b expected 0/0", IRQ, InterruptRequest);
        end
        reset = 1'b1;
        idle(10);
        for (int c = 0; c < NUM_CH; c++) begin
            peek(c, 2, v);
            checks++;
            if (v !== 32'h0) begin errors++; $display("FAIL mid_after_count ch%0d: got %h expected 0", c, v); end
        end
        checks++;
        if (InterruptRequest !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_irq: got %b expected 0", InterruptRequest);
        end
    endtask

    task automatic test_random();
        logic [31:0] v, d;
        logic we;
        int ch, r;
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        for (int n = 0; n < 300; n++) begin
            we = ($urandom_range(0, 2) == 0);
            ch = $urandom_range(0, NUM_CH - 1);
            r  = $urandom_range(0, 3);
            case (r)
                0: d = (32'($urandom_range(0, 3)) << 4) | ($urandom & 32'hF);
                1: d = 32'($urandom_range(0, 6));
                2: d = $urandom_range(0, 1) ? 32'($urandom_range(0, 6))
                                            : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: d = $urandom;
            endcase
            step(we, ch, r, d);
            for (int c = 0; c < NUM_CH; c++)
                for (int rr = 2; rr < 4; rr++) begin
                    peek(c, rr, v);
                    checks++;
                    if (v !== exp_read(c, rr)) begin
                        errors++;
                        $display("FAIL random cyc%0d ch%0d reg%0d: got %h expected %h",
                                 n, c, rr, v, exp_read(c, rr));
                    end
                end
            peek(ch, r, v);
            checks++;
            if (v !== exp_read(ch, r)) begin
                errors++;
                $display("FAIL random_rd cyc%0d ch%0d reg%0d: got %h expected %h", n, ch, r, v, exp_read(ch, r));
            end
            checks++;
            if (IRQ !== exp_irq() || InterruptRequest !== (|exp_irq())) begin
                errors++;
                $display("FAIL random_irq cyc%0d: got %b/%b expected %b", n, IRQ, InterruptRequest, exp_irq());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_oneshot();
        test_autoreload();
        test_freerun();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
